// File: rtl/ru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ru_pkg
// Description : Shared defaults and types for the multiport register unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ru_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_idx_t;
    typedef logic [DEF_XLEN-1:0] xword_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/ru_busy_table.sv
`default_nettype none
// ============================================================================
// Module      : ru_busy_table
// Description : Busy-bit scoreboard; set on issue, cleared on writeback/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ru_busy_table
    import ru_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_rd,
    input  logic [NWR-1:0]    wb_en,
    input  logic [NWR*AW-1:0] wb_rd,
    input  logic              flush,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_wb_hit;
    logic [NREGS-1:0] w_busy_next;

    always_comb begin
        w_wb_hit = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wb_en[w]) begin
                w_wb_hit[wb_rd[w*AW +: AW]] = 1'b1;
            end
        end
    end

    // Issue is applied after the writeback clear so the newer producer keeps the bit.
    always_comb begin
        w_busy_next = r_busy & ~w_wb_hit;
        if (issue_en) begin
            w_busy_next[issue_rd] = 1'b1;
        end
        if (flush) begin
            w_busy_next = '0;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/ru_multiport.sv
`default_nettype none
// ============================================================================
// Module      : ru_multiport
// Description : Parametrised register unit with write bypass and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module ru_multiport
    import ru_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      RUwrite,
    input  logic [NWR*AW-1:0]   rd,
    input  logic [NWR*XLEN-1:0] RUdw,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] RU,
    output logic [NRD-1:0]      rs_ready,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    localparam logic [AW-1:0] c_zero_idx = AW'(REG_ZERO);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;

    // Ascending port order makes the highest-index writer win on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (RUwrite[w] && (rd[w*AW +: AW] != c_zero_idx)) begin
                    r_regs[rd[w*AW +: AW]] <= RUdw[w*XLEN +: XLEN];
                end
            end
        end
    end

    ru_busy_table #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_busy_table (
        .clk      (clk),
        .rst      (rst),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .wb_en    (RUwrite),
        .wb_rd    (rd),
        .flush    (flush),
        .busy     (w_busy)
    );

    assign busy_vec = w_busy;

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rd_port
            logic [AW-1:0]   w_idx;
            logic [XLEN-1:0] w_val;
            logic            w_fwd;

            assign w_idx = rs[p*AW +: AW];

            // Reset masks the bypass too, so reads are zero for the whole reset window.
            always_comb begin
                w_val = r_regs[w_idx];
                w_fwd = 1'b0;
                for (int w = 0; w < NWR; w++) begin
                    if (RUwrite[w] && (rd[w*AW +: AW] == w_idx)) begin
                        w_val = RUdw[w*XLEN +: XLEN];
                        w_fwd = 1'b1;
                    end
                end
                if (rst || (w_idx == c_zero_idx)) begin
                    w_val = '0;
                    w_fwd = 1'b0;
                end
            end

            assign RU[p*XLEN +: XLEN] = w_val;
            assign rs_ready[p]        = rst | w_fwd | ~w_busy[w_idx];
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/ru_multiport.md
Name: ru_multiport

Overview:
Parametrised successor to the single-write, dual-read register unit for the segmented RISC-V core.
- Configurable data width, register count, read-port count and write-port count.
- Same-cycle write-to-read bypass: a read sees a value being written in the same cycle.
- Busy-bit scoreboard: the decode stage can detect RAW hazards without a separate hazard unit.
- Sits between ID (reads, issue) and WB (writes).

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, number of architectural registers; power of two; x0 hardwired to zero.
NRD, 2, number of read ports.
NWR, 1, number of write ports (1..4).
AW, $clog2(NREGS), register index width (derived; not overridden).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
RUwrite  in  NWR  per-write-port write enable.
rd  in  NWR*AW  per-write-port destination index.
RUdw  in  NWR*XLEN  per-write-port write data.
rs  in  NRD*AW  per-read-port source index.
RU  out  NRD*XLEN  per-read-port read data.
rs_ready  out  NRD  1 = the register read on that port has no outstanding producer.
issue_en  in  1  marks issue_rd as busy (instruction leaving ID).
issue_rd  in  AW  destination of the issued instruction.
flush  in  1  clears all busy bits (pipeline flush); register contents are kept.
busy_vec  out  NREGS  debug view of the scoreboard.

Behaviour:
Reset:
- rst asserted at any time clears all registers and busy bits immediately.
- While rst is high: RU = 0, rs_ready = all 1, busy_vec = 0.
- Writes and issues are ignored while rst is high.

Write:
- On the posedge, port w with RUwrite[w]=1 and rd[w]!=0 stores RUdw[w] into reg[rd[w]].
- x0 writes are silently dropped.
- If two ports write the same rd in one cycle, the highest port index wins.

Read:
- Combinational, zero latency.
- rs=0 returns 0.
- Otherwise, if any port w has RUwrite[w]=1 and rd[w]==rs (nonzero), the highest such w's RUdw is forwarded.
- Otherwise the stored value is returned.

Scoreboard:
- busy[i] sets on the posedge when issue_en=1 and issue_rd=i!=0.
- busy[i] clears on the posedge when any write port writes i.
- Issue and writeback to the same i in the same cycle: busy stays 1 (the newer producer owns it).
- flush=1 clears all bits at the posedge and takes priority over a same-cycle issue.
- busy[0] is always 0.

rs_ready:
- rs_ready[p] = ~busy[rs[p]], OR'ed with "a write to rs[p] is occurring this cycle".
- This lets a consumer proceed on the forwarded value.
- An issue in the same cycle does not affect rs_ready until the next cycle.

Other rules:
- No wrap/overflow concerns: indices are full-range by construction (NREGS = 2^AW).

Decomposition:
- Package ru_pkg holds: XLEN and NREGS defaults, typedef reg_idx_t (logic [AW-1:0]), typedef xword_t (logic [XLEN-1:0]), constant REG_ZERO = 0.
- Sub-module ru_busy_table holds the scoreboard: issue, writeback-clear and flush inputs; busy vector output.
- ru_multiport instantiates ru_busy_table; the storage array and bypass muxes live in the top module.

Test Plan:
1. Reset release, rs={0,0} -> RU={0,0}, rs_ready=2'b11. Then assert rst mid-run after writes -> all reads return 0 immediately (asynchronous).
2. Write x21=0xAAAAAA95, then x18=0xF565FA95 on successive cycles; then rs={21,18} -> RU={0xAAAAAA95, 0xF565FA95}.
3. Same-cycle bypass: RUwrite=1, rd=5, RUdw=0x12345678 with rs[0]=5 in that cycle -> RU[0]=0x12345678 before the edge. Also write to x0 with 0xFFFFFFFF -> reading rs=0 returns 0.
4. NWR=2, both ports write rd=7 (0x1 on port 0, 0x2 on port 1) -> reg7 = 0x2, and the bypass shows 0x2.
5. Scoreboard sequence:
   - issue_rd=9 -> next cycle rs=9 gives rs_ready=0.
   - Write x9=0x55 -> rs_ready=1 in the write cycle; busy_vec[9]=0 after the edge.
   - Issue and write x9 in the same cycle -> busy_vec[9] stays 1.
6. Issue x3, x4, x5, then flush=1 together with issue x6 -> busy_vec=0 after the edge, and x3's register value is unchanged.
